// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with centre-of-bit sampling feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity checked, bad bytes dropped).
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        rxd,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        framing_error,
    output logic        overflow_error,
    output logic        parity_error,
    output logic [15:0] byte_count
);

    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [1:0]         sync_q, sync_d;
    logic [2:0]         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               framing_q, framing_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        count_q, count_d;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][7:0] mem_q, mem_d;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               parity_q, parity_d;
`endif

    logic rxd_s, tick, push_req, push_ok, pop, empty, full;

    assign rxd_s = sync_q[1];
    assign tick  = (timer_q == '0);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop   = rd_en && !empty;

    always_comb begin
        sync_d    = {sync_q[0], rxd};
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        framing_d = framing_q;
        push_req  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    timer_d = HALF_BIT;
                end
            end
            S_START: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (!rxd_s) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    timer_d = FULL_BIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rxd_s;
                    timer_d        = FULL_BIT;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    // even parity: data bits plus parity bit must XOR to zero
                    par_bad_d = ^{shift_q, rxd_s};
                    parity_d  = parity_q | par_bad_d;
                    timer_d   = FULL_BIT;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                    push_req = !par_bad_q;
`else
                    push_req = 1'b1;
`endif
                    state_d  = S_IDLE;
                end else begin
                    framing_d = 1'b1;
                    state_d   = S_BREAK;
                end
            end
            S_BREAK: begin
                // hold off until the line returns high so a stuck-low rxd cannot retrigger
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
        push_ok    = push_req && (!full || pop);
        overflow_d = overflow_q | (push_req && full && !pop);
        count_d    = count_q + 16'(push_ok);
        wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        mem_d      = mem_q;
        if (push_ok) mem_d[wr_ptr_q[FIFO_AW-1:0]] = shift_q;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            framing_q  <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= 16'h0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_q   <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            framing_q  <= framing_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            parity_q   <= parity_d;
`endif
        end
    end

    // storage needs no reset; rd_data is masked while the FIFO is empty
    always_ff @(posedge clk_50) begin
        mem_q <= mem_d;
    end

    assign rd_valid       = !empty;
    assign rd_data        = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign framing_error  = framing_q;
    assign overflow_error = overflow_q;
    assign byte_count     = count_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error   = parity_q;
`else
    assign parity_error   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in, expected bytes queued, pops compared in order.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_rx_fifo;

    localparam int CPB = 434;
    localparam int FAW = 3;

    logic        clk_50 = 1'b0;
    logic        reset  = 1'b1;
    logic        rxd    = 1'b1;
    logic        rd_en  = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        framing_error;
    logic        overflow_error;
    logic        parity_error;
    logic [15:0] byte_count;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(FAW)) dut (
        .clk_50(clk_50), .reset(reset), .rxd(rxd), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .framing_error(framing_error), .overflow_error(overflow_error),
        .parity_error(parity_error), .byte_count(byte_count)
    );

    always #10 clk_50 = ~clk_50;

    initial begin
        #(64'd5_000_000);
        $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_50);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clks(CPB);
    endtask

    // one frame; flip_par inverts the even-parity bit in the parity build
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic flip_par);
        @(posedge clk_50);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ flip_par);
`else
        if (flip_par) wait_clks(0);
`endif
        send_bit(stop_bit);
        wait_clks(4);
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        reset = 1'b1;
        rxd   = 1'b1;
        rd_en = 1'b0;
        wait_clks(3);
        @(negedge clk_50);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_50);
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        vectors++;
        if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        vectors++;
        if ({framing_error, overflow_error, parity_error} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %b want 000", {framing_error, overflow_error, parity_error});
        end
        vectors++;
        if (byte_count !== 16'h0000) begin miscompares++; $display("FAIL reset_count: got %h want 0000", byte_count); end
    endtask

    task automatic test_two_bytes();
        do_reset();
        send_byte(8'h55, 1'b1, 1'b0); exp_q.push_back(8'h55);
        send_byte(8'hA3, 1'b1, 1'b0); exp_q.push_back(8'hA3);
        @(negedge clk_50);
        vectors++;
        if (byte_count !== 16'd2) begin miscompares++; $display("FAIL two_count: got %0d want 2", byte_count); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                miscompares++; $display("FAIL two_pop: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, exp_b);
            end
            rd_en = 1'b1; @(negedge clk_50); rd_en = 1'b0;
        end
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL two_empty: got valid=%b want 0", rd_valid); end
    endtask

    task automatic test_glitch();
        do_reset();
        @(posedge clk_50);
        rxd = 1'b0;
        wait_clks(100);
        rxd = 1'b1;
        wait_clks(10 * CPB);
        @(negedge clk_50);
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: got %b want 0", rd_valid); end
        vectors++;
        if ({framing_error, overflow_error, parity_error} !== 3'b000) begin
            miscompares++; $display("FAIL glitch_flags: got %b want 000", {framing_error, overflow_error, parity_error});
        end
        vectors++;
        if (byte_count !== 16'd0) begin miscompares++; $display("FAIL glitch_count: got %0d want 0", byte_count); end
    endtask

    task automatic test_framing();
        do_reset();
        send_byte(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        wait_clks(2000);
        rxd = 1'b1;
        wait_clks(2 * CPB);
        send_byte(8'h7E, 1'b1, 1'b0); exp_q.push_back(8'h7E);
        @(negedge clk_50);
        vectors++;
        if (framing_error !== 1'b1) begin miscompares++; $display("FAIL frame_flag: got %b want 1", framing_error); end
        vectors++;
        if (byte_count !== 16'd1) begin miscompares++; $display("FAIL frame_count: got %0d want 1", byte_count); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                miscompares++; $display("FAIL frame_pop: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, exp_b);
            end
            rd_en = 1'b1; @(negedge clk_50); rd_en = 1'b0;
        end
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL frame_empty: got valid=%b want 0", rd_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
            if (i <= (1 << FAW)) exp_q.push_back(8'(i));
        end
        @(negedge clk_50);
        vectors++;
        if (overflow_error !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow_error); end
        vectors++;
        if (byte_count !== 16'd8) begin miscompares++; $display("FAIL ovf_count: got %0d want 8", byte_count); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                miscompares++; $display("FAIL ovf_pop: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, exp_b);
            end
            rd_en = 1'b1; @(negedge clk_50); rd_en = 1'b0;
        end
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got valid=%b want 0", rd_valid); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        @(posedge clk_50);
        rxd = 1'b0;
        wait_clks(CPB);
        rxd = 1'b1;
        wait_clks(4 * CPB + CPB / 2);
        @(negedge clk_50);
        reset = 1'b1;
        wait_clks(2);
        @(negedge clk_50);
        reset = 1'b0;
        wait_clks(2 * CPB);
        send_byte(8'h12, 1'b1, 1'b0); exp_q.push_back(8'h12);
        @(negedge clk_50);
        vectors++;
        if ({framing_error, overflow_error, parity_error} !== 3'b000) begin
            miscompares++; $display("FAIL rstmid_flags: got %b want 000", {framing_error, overflow_error, parity_error});
        end
        vectors++;
        if (byte_count !== 16'd1) begin miscompares++; $display("FAIL rstmid_count: got %0d want 1", byte_count); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                miscompares++; $display("FAIL rstmid_pop: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, exp_b);
            end
            rd_en = 1'b1; @(negedge clk_50); rd_en = 1'b0;
        end
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_empty: got valid=%b want 0", rd_valid); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_byte(8'h07, 1'b1, 1'b0); exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1, 1'b1);
        @(negedge clk_50);
        vectors++;
        if (parity_error !== 1'b1) begin miscompares++; $display("FAIL par_flag: got %b want 1", parity_error); end
        vectors++;
        if (framing_error !== 1'b0) begin miscompares++; $display("FAIL par_framing: got %b want 0", framing_error); end
        vectors++;
        if (byte_count !== 16'd1) begin miscompares++; $display("FAIL par_count: got %0d want 1", byte_count); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                miscompares++; $display("FAIL par_pop: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, exp_b);
            end
            rd_en = 1'b1; @(negedge clk_50); rd_en = 1'b0;
        end
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL par_empty: got valid=%b want 0", rd_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_bytes();
        test_glitch();
        test_framing();
        test_overflow();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
